// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC and buffers fetched words in a circular queue.
// Optional FETCH_BYPASS_EN forwards a fetched word straight to the head outputs when the queue is empty.
module fetch_queue_unit #(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  input  logic [31:0]      imemload,
  input  logic             ihit,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             deq,
  output logic             valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [31:0]      instr_pc4,
  output logic [CNT_W-1:0] count,
  output logic             halt_seen
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [5:0]       HALT_OP  = 6'b111111;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      fpc;
  logic [31:0]      fpc4;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             halt_q;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_pc4   [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wr_en;
  logic is_halt;

  assign fpc4     = fpc + 32'd4;
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign imemREN  = ~full & ~halt_q & ~redirect;
  assign imemaddr = fpc;
  assign push     = imemREN & ihit;
  assign is_halt  = (imemload[31:26] == HALT_OP);
  assign pop      = deq & ~empty;
  assign count    = cnt;
  assign halt_seen = halt_q;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  assign bypass = empty & push;
  // A forwarded word that decode takes in the same cycle never occupies a slot.
  assign wr_en  = push & ~(bypass & deq);

  always_comb begin
    valid     = ~empty | bypass;
    instr     = q_instr[rd_ptr];
    instr_pc  = q_pc[rd_ptr];
    instr_pc4 = q_pc4[rd_ptr];
    if (bypass) begin
      instr     = imemload;
      instr_pc  = fpc;
      instr_pc4 = fpc4;
    end
  end
`else
  assign wr_en = push;

  always_comb begin
    valid     = ~empty;
    instr     = q_instr[rd_ptr];
    instr_pc  = q_pc[rd_ptr];
    instr_pc4 = q_pc4[rd_ptr];
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fpc    <= PC_INIT;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      halt_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_pc4[i]   <= '0;
      end
    end else if (redirect) begin
      // Redirect wins over any fetch return or decode consume this cycle.
      fpc    <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      halt_q <= 1'b0;
    end else begin
      if (wr_en) begin
        q_instr[wr_ptr] <= imemload;
        q_pc[wr_ptr]    <= fpc;
        q_pc4[wr_ptr]   <= fpc4;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (push) begin
        fpc <= fpc4;
        if (is_halt) halt_q <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus random traffic checked against a queue-based model.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic [31:0]      imemload = '0;
  logic             ihit = 1'b0;
  logic             redirect = 1'b0;
  logic [31:0]      redirect_pc = '0;
  logic             deq = 1'b0;
  logic             valid;
  logic [31:0]      instr;
  logic [31:0]      instr_pc;
  logic [31:0]      instr_pc4;
  logic [CNT_W-1:0] count;
  logic             halt_seen;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc = 32'h0;
  bit          m_halt = 1'b0;

  fetch_queue_unit #(.PC_INIT(32'h0), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .valid(valid), .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4),
    .count(count), .halt_seen(halt_seen)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit          e_ren;
    bit          e_valid;
    logic [31:0] hw;
    logic [31:0] hpc;
    e_ren   = (mq.size() < DEPTH) && !m_halt && !redirect;
    e_valid = (mq.size() != 0);
    hw  = '0;
    hpc = '0;
    if (e_valid) begin
      hw  = mq[0].w;
      hpc = mq[0].pc;
    end
`ifdef FETCH_BYPASS_EN
    if (mq.size() == 0 && e_ren && ihit) begin
      e_valid = 1'b1;
      hw  = imemload;
      hpc = m_fpc;
    end
`endif
    chk("imemREN", 32'(imemREN), 32'(e_ren));
    chk("imemaddr", imemaddr, m_fpc);
    chk("count", 32'(count), 32'(mq.size()));
    chk("halt_seen", 32'(halt_seen), 32'(m_halt));
    chk("valid", 32'(valid), 32'(e_valid));
    if (e_valid) begin
      chk("instr", instr, hw);
      chk("instr_pc", instr_pc, hpc);
      chk("instr_pc4", instr_pc4, hpc + 32'd4);
    end
  endtask

  task automatic model_step();
    bit ren;
    bit push;
    bit pop;
    bit consumed;
    if (redirect) begin
      mq.delete();
      m_fpc  = redirect_pc;
      m_halt = 1'b0;
      return;
    end
    ren      = (mq.size() < DEPTH) && !m_halt;
    push     = ren && ihit;
    pop      = deq && (mq.size() != 0);
    consumed = 1'b0;
`ifdef FETCH_BYPASS_EN
    consumed = push && deq && (mq.size() == 0);
`endif
    if (pop) void'(mq.pop_front());
    if (push && !consumed) mq.push_back('{imemload, m_fpc});
    if (push) begin
      if (imemload[31:26] == 6'h3F) m_halt = 1'b1;
      m_fpc = m_fpc + 32'd4;
    end
  endtask

  task automatic cycle(input bit r, input logic [31:0] rpc, input bit h,
                       input logic [31:0] ld, input bit d);
    @(negedge CLK);
    redirect = r; redirect_pc = rpc; ihit = h; imemload = ld; deq = d;
    #1;
    compare_model();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  initial begin
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    #10 nRST = 1'b1;
    #1;
    chk("post_rst_addr", imemaddr, 32'h0);
    chk("post_rst_ren", 32'(imemREN), 32'd1);
    chk("post_rst_instr", instr, 32'h0);
    chk("post_rst_pc", instr_pc, 32'h0);
    chk("post_rst_pc4", instr_pc4, 32'h0);

    // fill to full
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 32'h2000_0000 + 32'(i), 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ren", 32'(imemREN), 32'd0);
    chk("fill_head_pc", instr_pc, 32'h0);
    chk("fill_head", instr, 32'h2000_0000);
    chk("fill_addr", imemaddr, 32'h10);

    // deq while full: no request in that cycle
    cycle(1'b0, '0, 1'b1, 32'h2000_0010, 1'b1);
    chk("deq_full_count", 32'(count), 32'd3);
    chk("deq_full_head_pc", instr_pc, 32'h4);
    chk("deq_full_addr", imemaddr, 32'h10);
    cycle(1'b0, '0, 1'b1, 32'h2000_0011, 1'b0);
    chk("refill_count", 32'(count), 32'd4);
    cycle(1'b0, '0, 1'b0, 32'h0, 1'b1);

    // redirect with simultaneous ihit and deq
    cycle(1'b1, 32'h40, 1'b1, 32'h2000_0099, 1'b1);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(valid), 32'd0);
    chk("redir_addr", imemaddr, 32'h40);

    // HALT at PC 8
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, '0, 1'b1, 32'h2001_0001, 1'b0);
    cycle(1'b0, '0, 1'b1, 32'h2001_0002, 1'b0);
    cycle(1'b0, '0, 1'b1, 32'hFC00_0000, 1'b0);
    chk("halt_seen", 32'(halt_seen), 32'd1);
    chk("halt_ren", 32'(imemREN), 32'd0);
    chk("halt_count", 32'(count), 32'd3);
    chk("halt_addr", imemaddr, 32'hC);
    cycle(1'b0, '0, 1'b1, 32'h2001_0003, 1'b1);
    cycle(1'b0, '0, 1'b1, 32'h2001_0004, 1'b1);
    chk("halt_head", instr, 32'hFC00_0000);
    chk("halt_head_pc", instr_pc, 32'h8);
    cycle(1'b0, '0, 1'b1, 32'h2001_0005, 1'b1);
    chk("halt_drained", 32'(count), 32'd0);
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("halt_cleared", 32'(halt_seen), 32'd0);
    chk("halt_resume_addr", imemaddr, 32'h0);

    // ihit toggling with continuous deq
    for (int k = 0; k < 6 * DEPTH; k++) begin
      cycle(1'b0, '0, (k % 2) == 0, 32'h2002_0000 + 32'(k), 1'b1);
      chk("toggle_count_le1", 32'(count <= 1), 32'd1);
    end
    chk("toggle_addr", imemaddr, 32'h30);

`ifdef FETCH_BYPASS_EN
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    redirect = 1'b0; ihit = 1'b1; imemload = 32'h2001_0005; deq = 1'b1;
    #1;
    chk("byp_valid", 32'(valid), 32'd1);
    chk("byp_instr", instr, 32'h2001_0005);
    compare_model();
    @(posedge CLK);
    model_step();
    #1;
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_addr", imemaddr, 32'h4);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit          r;
      bit          h;
      bit          d;
      logic [31:0] rpc;
      logic [31:0] ld;
      r   = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      h   = ($urandom_range(0, 9) < 7);
      ld  = $urandom;
      if (ld[31:26] == 6'h3F && $urandom_range(0, 3) != 0) ld[26] = 1'b0;
      d   = ($urandom_range(0, 99) < (((n / 500) % 2 == 0) ? 30 : 80));
      cycle(r, rpc, h, ld, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end for the pipelined datapath, replacing the single-entry IF stage.
- Owns the fetch PC and issues requests on the icache side of datapath_cache_if (imemREN/imemaddr/imemload/ihit).
- Buffers up to DEPTH fetched instructions, each with its PC and PC+4, in a circular queue that decode drains.
- Supports a single-cycle redirect/flush for branches and jumps resolved downstream.
- Detects HALT and stops fetching until the next redirect.

Parameters:
PC_INIT, 32'h0, fetch PC value after reset
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived; do not override)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
imemREN  out  1  instruction read request
imemaddr  out  32  fetch address (= fetch PC)
imemload  in  32  instruction word, valid when ihit
ihit  in  1  icache hit / data-ready for current imemaddr
redirect  in  1  flush queue and load redirect_pc (from EX/MEM pcsrc logic)
redirect_pc  in  32  new fetch PC on redirect
deq  in  1  decode consumes head entry this cycle
valid  out  1  head entry valid
instr  out  32  head instruction word
instr_pc  out  32  head instruction PC
instr_pc4  out  32  head PC + 4
count  out  CNT_W  current occupancy, 0..DEPTH
halt_seen  out  1  HALT fetched; fetching suspended

Behaviour:
Reset and clocking:
- Reset is nRST, asynchronous, active-low; clock is CLK.
- Reset values: fpc=PC_INIT, rd/wr pointers=0, count=0, halt_seen=0, all queue storage=0.
- After reset: valid=0, instr/instr_pc/instr_pc4=0, imemaddr=PC_INIT, imemREN=1.

Request:
- imemREN = ~full & ~halt_seen & ~redirect.
- full = (count==DEPTH).
- imemaddr = fpc, combinational.

Push:
- push = imemREN & ihit.
- On push: write {imemload, fpc, fpc+4} at wr_ptr; wr_ptr <= wr_ptr+1 mod DEPTH; fpc <= fpc+4.
- Fetch-to-valid latency is 1 cycle: an entry pushed at edge N shows valid=1 after edge N.

Pop:
- pop = deq & valid.
- On pop: rd_ptr <= rd_ptr+1 mod DEPTH.
- deq while empty is ignored (no pointer or count change).

Count:
- push & pop together: count unchanged, both pointers advance.
- Otherwise count increments on push and decrements on pop.

HALT:
- If a pushed word has imemload[31:26]==HALT (6'b111111), halt_seen <= 1 on that edge.
- The HALT word itself is enqueued.
- No further requests are issued while halt_seen=1.

Full:
- No request is issued when full, even if deq is asserted that cycle; the slot is refilled the following cycle. This is conservative and avoids a comb path from deq to imemREN.

Redirect (highest priority):
- On the edge with redirect=1: rd_ptr=wr_ptr=0, count=0, fpc <= redirect_pc, halt_seen <= 0.
- Any ihit/imemload and any deq in that cycle are discarded.
- valid=0 on the next cycle; the first fetch from redirect_pc is requested on the next cycle.

Arithmetic:
- PC arithmetic is 32-bit modulo; fpc=32'hFFFFFFFC wraps to 0.

Head outputs:
- instr/instr_pc/instr_pc4 present the entry at rd_ptr, combinationally from storage.
- These outputs are don't-care when valid=0, except after reset, when they read 0.

Optional Feature:
FETCH_BYPASS_EN
- When defined, and the queue is empty with push=1 and no redirect: valid=1 and instr/instr_pc/instr_pc4 are driven directly from imemload/fpc/fpc+4 in the same cycle.
- If deq=1 in that cycle, the word is consumed without being written: count stays 0, pointers are unchanged, fpc advances.
- If deq=0, the word is written normally.
- HALT detection is unchanged.
- When not defined, fetch-to-valid latency is always 1 cycle and valid depends only on count.

Test Plan:
1. Reset with PC_INIT=0, ihit=1 every cycle, deq=0, DEPTH=4 -> addresses 0,4,8,C requested; count reaches 4; imemREN=0 while full; instr_pc=0.
2. Full queue, deq=1 for one cycle -> count 4->3, imemREN=0 during the deq cycle, next request at 0x10 on the following cycle; head becomes PC 4.
3. Queue holding 3 entries, redirect=1 with redirect_pc=0x40, ihit=1 and deq=1 in the same cycle -> next cycle count=0, valid=0, imemaddr=0x40; both discarded events have no effect.
4. HALT word (0xFC000000) fetched at PC 0x8 -> enqueued, halt_seen=1, imemREN=0; queue drains to HALT; then redirect to 0x0 -> halt_seen=0, fetching resumes at 0x0.
5. ihit toggling 1,0,1,0 with deq=1 every cycle -> no duplicate or lost PCs; sequence 0,4,8 each appears exactly once; count never exceeds 1; pointers wrap correctly over 3×DEPTH fetches.
6. With FETCH_BYPASS_EN, empty queue, ihit=1, deq=1, imemload=0x20010005 at PC 0x0 -> valid=1 and instr=0x20010005 in the same cycle; count stays 0; fpc=4 next cycle.
